// File: rtl/mpu_clock_ctrl_if.sv
// Signal bundle between the MPU clock controller and its surroundings.
// The run, halt and step controls go into the controller. The phase clock,
// its edge strobes and the status signals come back out.
interface mpu_clock_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             run_mode;
    logic             halt_req;
    logic             step_press;
    logic             mpu_clk;
    logic             phi_fall;
    logic             phi_rise;
    logic             halted;
    logic [CNT_W-1:0] cycle_count;

    modport master (
        output run_mode, halt_req, step_press,
        input  mpu_clk, phi_fall, phi_rise, halted, cycle_count
    );

    modport slave (
        input  run_mode, halt_req, step_press,
        output mpu_clk, phi_fall, phi_rise, halted, cycle_count
    );
endinterface

// File: rtl/mpu_clock_ctrl.sv
// MPU phase-clock generator with free-run, halt and debounced single-step.
// mpu_clk idles high. Each phase lasts HALF_PERIOD clk cycles, and a halt
// only ever takes effect at the end of a complete high phase.
module mpu_clock_ctrl #(
    parameter int HALF_PERIOD = 25,
    parameter int DB_CYCLES   = 500000,
    parameter int CNT_W       = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    mpu_clock_ctrl_if.slave bus
);

    localparam int PH_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        HALTED    = 2'd0,
        RUN       = 2'd1,
        STEP_PRE  = 2'd2,
        STEP_POST = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [PH_W-1:0]  ph_cnt;
    logic [PH_W-1:0]  ph_cnt_next;
    logic             mpu_clk_q;
    logic             mpu_clk_next;
    logic             phi_fall_q;
    logic             phi_fall_next;
    logic             phi_rise_q;
    logic             phi_rise_next;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_next;

    logic             sync_meta;
    logic             sync_q;
    logic             db_level;
    logic             db_prev;
    logic [DB_W-1:0]  db_cnt;
    logic             step_evt;
    logic             terminal;
    logic             run_ok;

    // Synchronise the raw push-button and debounce it into a stable level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
            db_level  <= 1'b0;
            db_prev   <= 1'b0;
            db_cnt    <= '0;
        end else begin
            sync_meta <= bus.step_press;
            sync_q    <= sync_meta;
            db_prev   <= db_level;
            if (sync_q == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
                db_level <= sync_q;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    // A step is the single clk where the debounced level has just gone high.
    // It acts only in HALTED. Any other state ignores it, so it is dropped.
    assign step_evt = db_level & ~db_prev;
    assign run_ok   = bus.run_mode & ~bus.halt_req;
    assign terminal = (state != HALTED) && (ph_cnt == PH_W'(HALF_PERIOD - 1));

    // Next-state logic: phases toggle only on terminal edges. A halt is
    // honoured only at the end of a high phase, so no phase is ever shortened.
    always_comb begin
        state_next    = state;
        mpu_clk_next  = mpu_clk_q;
        phi_fall_next = 1'b0;
        phi_rise_next = 1'b0;
        count_next    = count_q;

        if (state == HALTED || terminal) begin
            ph_cnt_next = '0;
        end else begin
            ph_cnt_next = ph_cnt + PH_W'(1);
        end

        case (state)
            HALTED: begin
                mpu_clk_next = 1'b1;
                if (run_ok) begin
                    state_next = RUN;
                end else if (step_evt) begin
                    state_next = STEP_PRE;
                end
            end
            RUN: begin
                if (terminal) begin
                    if (mpu_clk_q && !run_ok) begin
                        state_next = HALTED;
                    end else if (mpu_clk_q) begin
                        mpu_clk_next  = 1'b0;
                        phi_fall_next = 1'b1;
                        count_next    = count_q + CNT_W'(1);
                    end else begin
                        mpu_clk_next  = 1'b1;
                        phi_rise_next = 1'b1;
                    end
                end
            end
            STEP_PRE: begin
                if (terminal) begin
                    mpu_clk_next  = 1'b0;
                    phi_fall_next = 1'b1;
                    count_next    = count_q + CNT_W'(1);
                    state_next    = STEP_POST;
                end
            end
            STEP_POST: begin
                if (terminal) begin
                    if (!mpu_clk_q) begin
                        mpu_clk_next  = 1'b1;
                        phi_rise_next = 1'b1;
                    end else begin
                        state_next = HALTED;
                    end
                end
            end
            default: begin
                state_next   = HALTED;
                mpu_clk_next = 1'b1;
            end
        endcase
    end

    // State, phase counter and registered outputs. Reset snaps mpu_clk high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HALTED;
            ph_cnt     <= '0;
            mpu_clk_q  <= 1'b1;
            phi_fall_q <= 1'b0;
            phi_rise_q <= 1'b0;
            count_q    <= '0;
        end else begin
            state      <= state_next;
            ph_cnt     <= ph_cnt_next;
            mpu_clk_q  <= mpu_clk_next;
            phi_fall_q <= phi_fall_next;
            phi_rise_q <= phi_rise_next;
            count_q    <= count_next;
        end
    end

    assign bus.mpu_clk     = mpu_clk_q;
    assign bus.phi_fall    = phi_fall_q;
    assign bus.phi_rise    = phi_rise_q;
    assign bus.halted      = (state == HALTED);
    assign bus.cycle_count = count_q;

endmodule

// File: tb/tb_mpu_clock_ctrl.sv
// Directed bench for mpu_clock_ctrl with HALF_PERIOD=4, DB_CYCLES=3, CNT_W=4.
// Inputs are driven and outputs sampled 1 time unit after each rising clk.
module tb_mpu_clock_ctrl;

    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;

    mpu_clock_ctrl_if #(.CNT_W(4)) bus ();

    mpu_clock_ctrl #(
        .HALF_PERIOD(4),
        .DB_CYCLES  (3),
        .CNT_W      (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // 10-unit clock period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic check_all(input string tag, input logic m, input logic h,
                             input logic f, input logic r, input logic [3:0] c);
        check_output({tag, ".mpu_clk"},     32'(bus.mpu_clk),     32'(m));
        check_output({tag, ".halted"},      32'(bus.halted),      32'(h));
        check_output({tag, ".phi_fall"},    32'(bus.phi_fall),    32'(f));
        check_output({tag, ".phi_rise"},    32'(bus.phi_rise),    32'(r));
        check_output({tag, ".cycle_count"}, 32'(bus.cycle_count), 32'(c));
    endtask

    initial begin
        compared       = 0;
        mismatched     = 0;
        rst_n          = 1'b0;
        bus.run_mode   = 1'b0;
        bus.halt_req   = 1'b0;
        bus.step_press = 1'b0;

        tick(2);
        check_all("reset", 1, 1, 0, 0, 4'd0);

        // Free run after reset release
        bus.run_mode = 1'b1;
        rst_n        = 1'b1;
        tick(1);
        check_all("run_entry", 1, 0, 0, 0, 4'd0);
        tick(3);
        check_all("pre_fall1", 1, 0, 0, 0, 4'd0);
        tick(1);
        check_all("fall1", 0, 0, 1, 0, 4'd1);
        tick(1);
        check_all("low1", 0, 0, 0, 0, 4'd1);
        tick(3);
        check_all("rise1", 1, 0, 0, 1, 4'd1);
        tick(4);
        check_all("fall2", 0, 0, 1, 0, 4'd2);

        // run_mode drops two clks into a low phase
        tick(2);
        bus.run_mode = 1'b0;
        tick(2);
        check_all("halt_rise", 1, 0, 0, 1, 4'd2);
        tick(3);
        check_all("halt_high", 1, 0, 0, 0, 4'd2);
        tick(1);
        check_all("halted", 1, 1, 0, 0, 4'd2);
        tick(4);
        check_all("halted_stable", 1, 1, 0, 0, 4'd2);

        // Clean single step: press held 10 clks
        bus.step_press = 1'b1;
        tick(5);
        check_all("step_db_wait", 1, 1, 0, 0, 4'd2);
        tick(1);
        check_all("step_pre", 1, 0, 0, 0, 4'd2);
        tick(4);
        check_all("step_fall", 0, 0, 1, 0, 4'd3);
        bus.step_press = 1'b0;
        tick(4);
        check_all("step_rise", 1, 0, 0, 1, 4'd3);
        tick(3);
        check_all("step_high", 1, 0, 0, 0, 4'd3);
        tick(1);
        check_all("step_done", 1, 1, 0, 0, 4'd3);
        tick(5);
        check_all("step_single", 1, 1, 0, 0, 4'd3);

        // Bouncing 2-clk pulses never pass the debouncer
        for (int i = 0; i < 3; i++) begin
            bus.step_press = 1'b1;
            tick(2);
            bus.step_press = 1'b0;
            tick(2);
        end
        tick(8);
        check_all("bounce", 1, 1, 0, 0, 4'd3);

        // Step during RUN is discarded; halt_req halts like run_mode=0
        bus.run_mode = 1'b1;
        tick(1);
        check_all("run2_entry", 1, 0, 0, 0, 4'd3);
        bus.step_press = 1'b1;
        tick(4);
        check_all("run2_fall1", 0, 0, 1, 0, 4'd4);
        tick(4);
        check_all("run2_rise1", 1, 0, 0, 1, 4'd4);
        bus.step_press = 1'b0;
        tick(4);
        check_all("run2_fall2", 0, 0, 1, 0, 4'd5);
        bus.halt_req = 1'b1;
        tick(4);
        check_all("hreq_rise", 1, 0, 0, 1, 4'd5);
        tick(4);
        check_all("hreq_halted", 1, 1, 0, 0, 4'd5);
        tick(6);
        check_all("hreq_stable", 1, 1, 0, 0, 4'd5);

        // Run condition and step event on the same edge: RUN wins
        bus.run_mode   = 1'b0;
        bus.halt_req   = 1'b0;
        bus.step_press = 1'b1;
        tick(5);
        check_all("tie_wait", 1, 1, 0, 0, 4'd5);
        bus.run_mode = 1'b1;
        tick(1);
        check_all("tie_entry", 1, 0, 0, 0, 4'd5);
        tick(4);
        check_all("tie_fall1", 0, 0, 1, 0, 4'd6);
        bus.step_press = 1'b0;
        tick(8);
        check_all("tie_fall2", 0, 0, 1, 0, 4'd7);
        bus.run_mode = 1'b0;
        tick(8);
        check_all("tie_halted", 1, 1, 0, 0, 4'd7);

        // Asynchronous reset during the STEP_POST low phase
        bus.step_press = 1'b1;
        tick(10);
        check_all("step2_fall", 0, 0, 1, 0, 4'd8);
        bus.step_press = 1'b0;
        tick(2);
        check_all("step2_low", 0, 0, 0, 0, 4'd8);
        rst_n = 1'b0;
        #1;
        check_all("async_reset", 1, 1, 0, 0, 4'd0);
        bus.run_mode = 1'b1;
        tick(1);
        check_all("reset_held", 1, 1, 0, 0, 4'd0);
        rst_n = 1'b1;
        tick(1);
        check_all("rerun_entry", 1, 0, 0, 0, 4'd0);

        // Free-run 16 falls: cycle_count wraps 15 -> 0
        tick(4);
        check_all("wrap_fall1", 0, 0, 1, 0, 4'd1);
        tick(8 * 14);
        check_all("wrap_fall15", 0, 0, 1, 0, 4'd15);
        tick(8);
        check_all("wrap_fall16", 0, 0, 1, 0, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
